// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v counters, active-low syncs, video_on and line/frame strobes.
// Latency: all outputs registered; syncs, video_on and strobes are cycle-aligned with the pixel_x/pixel_y they describe.
// Backpressure: none, free-running; downstream samples pixel_x/pixel_y/video_on only while pixel_tick=1.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int TICK_DIV = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (TICK_DIV < 1) begin : g_div_check
        $error("vga_sync_gen: TICK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] div_next;
    logic             tick_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    always_comb begin
        div_next  = (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
        tick_next = (div_next == DIV_LAST);
        x_next    = pixel_x;
        y_next    = pixel_y;
        if (pixel_tick) begin
            if (pixel_x == H_LAST) begin
                x_next = '0;
                y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
    end

    // Decoding the next-state counters keeps syncs and strobes aligned with the counter values they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            divider    <= '0;
            pixel_tick <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b1;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            divider    <= div_next;
            pixel_tick <= tick_next;
            pixel_x    <= x_next;
            pixel_y    <= y_next;
            hsync      <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync      <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            video_on   <= (x_next < H_VIS) && (y_next < V_VIS);
            line_end   <= tick_next && (x_next == H_LAST);
            frame_end  <= tick_next && (x_next == H_LAST) && (y_next == V_LAST);
        end
    end

endmodule
